// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Groups the instruction-fetch stage's bus signals: hazard/redirect inputs
//   from the ID stage, the instruction-memory port and the IF/ID register
//   outputs.
//   master : the fetch stage (drives imem_addr and the IF/ID outputs)
//   slave  : the surrounding pipeline/memory (drives stall, redirects,
//            jr_target and imem_rdata)
interface fetch_stage_if;
  logic        stall;
  logic        isb;
  logic        isjal;
  logic        isjr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc8_id;
  logic        valid_id;
  logic        pc_err;

  modport master (
    input  stall, isb, isjal, isjr, jr_target, imem_rdata,
    output imem_addr, instr_id, pc_id, pc8_id, valid_id, pc_err
  );

  modport slave (
    output stall, isb, isjal, isjr, jr_target, imem_rdata,
    input  imem_addr, instr_id, pc_id, pc8_id, valid_id, pc_err
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, the
//   next-PC selection and the IF/ID pipeline register. Branches use an
//   architectural delay slot, so nothing is ever flushed.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_stage_if.master
//            in  stall, isb, isjal, isjr, jr_target[31:0], imem_rdata[31:0]
//            out imem_addr[31:0] (= PC), instr_id, pc_id, pc8_id, valid_id,
//                pc_err
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   When defined, a jr to a non-word-aligned target is forced down to the
//   word boundary and a sticky pc_err flag is raised. When undefined the jr
//   target is used as-is and pc_err is tied to 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC          = 32'h0000_3000,
  parameter int          ID_PC8_EN_DEFAULT = 1
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  // ID_PC8_EN_DEFAULT is reserved: every setting links at PC+8.
  localparam logic [31:0] LINK_OFFSET = (ID_PC8_EN_DEFAULT != 0) ? 32'd8 : 32'd8;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  logic [31:0] pc_id_plus4;
  logic [31:0] br_offset;
  logic [31:0] pc_br;
  logic [31:0] pc_j;
  logic [31:0] pc_jr;

  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc8_id;
  logic        valid_id;

  // Candidate targets. Branch and jump targets are relative to the
  // instruction sitting in ID, not to the current fetch PC.
  assign pc_seq      = pc + 32'd4;
  assign pc_id_plus4 = pc_id + 32'd4;
  assign br_offset   = {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
  assign pc_br       = pc_id_plus4 + br_offset;
  assign pc_j        = {pc_id_plus4[31:28], instr_id[25:0], 2'b00};

`ifdef PC_ALIGN_CHECK_EN
  logic jr_misaligned;
  logic pc_err;

  assign pc_jr         = {bus.jr_target[31:2], 2'b00};
  assign jr_misaligned = |bus.jr_target[1:0];

  // Sticky flag: set by the edge that actually takes a misaligned jr, and
  // only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_err <= 1'b0;
    end else if (!bus.stall && valid_id && bus.isjr && jr_misaligned) begin
      pc_err <= 1'b1;
    end
  end

  assign bus.pc_err = pc_err;
`else
  assign pc_jr      = bus.jr_target;
  assign bus.pc_err = 1'b0;
`endif

  // Next-PC select. Redirects only count when ID holds a real instruction;
  // the priority order only matters for combinations the decoder never
  // produces.
  always_comb begin
    pc_next = pc_seq;
    if (valid_id) begin
      if (bus.isjr) begin
        pc_next = pc_jr;
      end else if (bus.isjal) begin
        pc_next = pc_j;
      end else if (bus.isb) begin
        pc_next = pc_br;
      end
    end
  end

  // PC register. A stall freezes it, which also discards any redirect seen
  // that cycle; ID will present the redirect again once the stall lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (!bus.stall) begin
      pc <= pc_next;
    end
  end

  // IF/ID register. The word fetched in the redirect cycle is the delay
  // slot and always enters ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_id <= 32'd0;
      pc_id    <= 32'd0;
      pc8_id   <= 32'd0;
      valid_id <= 1'b0;
    end else if (!bus.stall) begin
      instr_id <= bus.imem_rdata;
      pc_id    <= pc;
      pc8_id   <= pc + LINK_OFFSET;
      valid_id <= 1'b1;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.instr_id  = instr_id;
  assign bus.pc_id     = pc_id;
  assign bus.pc8_id    = pc8_id;
  assign bus.valid_id  = valid_id;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. An architectural model of the fetch
//   stage runs alongside the DUT and is compared on every falling edge;
//   literal checks at key points pin the model to hand-worked values.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC          (RESET_PC),
    .ID_PC8_EN_DEFAULT (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Instruction memory: every word equals its address, except one optional
  // override location used to plant a branch or jump.
  logic        ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_word;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    if (ovr_en && addr == ovr_addr) return ovr_word;
    return addr;
  endfunction

  always_comb bus.imem_rdata = imem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: current fetch PC plus the instruction held in ID.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic [31:0] m_pc8;
  logic        m_valid;
  logic        m_err;

  function automatic logic [31:0] model_next_pc();
    int signed imm;
    if (!m_valid) return m_pc + 32'd4;
    if (bus.isjr) begin
`ifdef PC_ALIGN_CHECK_EN
      return bus.jr_target & ~32'd3;
`else
      return bus.jr_target;
`endif
    end
    if (bus.isjal) return ((m_pcid + 32'd4) & 32'hF000_0000) | (32'(m_instr[25:0]) * 32'd4);
    if (bus.isb) begin
      imm = int'($signed(m_instr[15:0]));
      return m_pcid + 32'd4 + 32'(imm * 4);
    end
    return m_pc + 32'd4;
  endfunction

  // Model update on each rising edge; async reset mirrors the spec rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= RESET_PC;
      m_instr <= 32'd0;
      m_pcid  <= 32'd0;
      m_pc8   <= 32'd0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else if (!bus.stall) begin
`ifdef PC_ALIGN_CHECK_EN
      if (m_valid && bus.isjr && bus.jr_target[1:0] != 2'b00) m_err <= 1'b1;
`endif
      m_pc    <= model_next_pc();
      m_instr <= imem_word(m_pc);
      m_pcid  <= m_pc;
      m_pc8   <= m_pc + 32'd8;
      m_valid <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m.imem_addr", bus.imem_addr, m_pc);
      checkOutput("m.instr_id", bus.instr_id, m_instr);
      checkOutput("m.pc_id", bus.pc_id, m_pcid);
      checkOutput("m.pc8_id", bus.pc8_id, m_pc8);
      checkOutput("m.valid_id", 32'(bus.valid_id), 32'(m_valid));
      checkOutput("m.pc_err", 32'(bus.pc_err), 32'(m_err));
    end
  end

  task automatic applyStimulus(input logic stall, input logic isb, input logic isjal,
                               input logic isjr, input logic [31:0] jr_target);
    bus.stall     = stall;
    bus.isb       = isb;
    bus.isjal     = isjal;
    bus.isjr      = isjr;
    bus.jr_target = jr_target;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Hold reset for two edges, then release it 1 unit after an edge.
  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ovr_en = 1'b0;
    ovr_addr = 32'd0;
    ovr_word = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    check_en = 1'b1;

    // Reset state and plain sequential fetch.
    doReset();
    checkOutput("rst.imem_addr", bus.imem_addr, 32'h0000_3000);
    checkOutput("rst.instr_id", bus.instr_id, 32'h0);
    checkOutput("rst.pc8_id", bus.pc8_id, 32'h0);
    checkOutput("rst.valid_id", 32'(bus.valid_id), 32'h0);
    tick(1);
    checkOutput("seq.imem_addr1", bus.imem_addr, 32'h0000_3004);
    checkOutput("seq.instr_id1", bus.instr_id, 32'h0000_3000);
    checkOutput("seq.pc8_id1", bus.pc8_id, 32'h0000_3008);
    checkOutput("seq.valid_id1", 32'(bus.valid_id), 32'h1);
    tick(1);
    checkOutput("seq.imem_addr2", bus.imem_addr, 32'h0000_3008);
    checkOutput("seq.instr_id2", bus.instr_id, 32'h0000_3004);
    tick(1);
    checkOutput("seq.imem_addr3", bus.imem_addr, 32'h0000_300C);
    checkOutput("seq.instr_id3", bus.instr_id, 32'h0000_3008);

    // Backward branch: beq at 0x3004, imm16 = -1, target 0x3004.
    ovr_en = 1'b1; ovr_addr = 32'h0000_3004; ovr_word = 32'h1000_FFFF;
    doReset();
    tick(2);
    checkOutput("beq.instr_id", bus.instr_id, 32'h1000_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(1);
    checkOutput("beq.slot_instr", bus.instr_id, 32'h0000_3008);
    checkOutput("beq.target", bus.imem_addr, 32'h0000_3004);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);

    // jal at 0x3000 with index 26'hC40, target 0x3100.
    ovr_en = 1'b1; ovr_addr = 32'h0000_3000; ovr_word = 32'h0C00_0C40;
    doReset();
    tick(1);
    checkOutput("jal.pc8_id", bus.pc8_id, 32'h0000_3008);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick(1);
    checkOutput("jal.slot_instr", bus.instr_id, 32'h0000_3004);
    checkOutput("jal.target", bus.imem_addr, 32'h0000_3100);

    // jr to 0x4000 held off by a two-cycle stall.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000);
    tick(2);
    checkOutput("jr.stall_pc", bus.imem_addr, 32'h0000_3100);
    checkOutput("jr.stall_instr", bus.instr_id, 32'h0000_3004);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000);
    tick(1);
    checkOutput("jr.target", bus.imem_addr, 32'h0000_4000);
    checkOutput("jr.slot_pc", bus.pc_id, 32'h0000_3100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Misaligned jr target 0x3006.
    ovr_en = 1'b0;
    doReset();
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3006);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
    checkOutput("align.pc", bus.imem_addr, 32'h0000_3004);
    checkOutput("align.err", 32'(bus.pc_err), 32'h1);
    tick(2);
    checkOutput("align.err_held", 32'(bus.pc_err), 32'h1);
`else
    checkOutput("align.pc", bus.imem_addr, 32'h0000_3006);
    checkOutput("align.err", 32'(bus.pc_err), 32'h0);
    tick(2);
    checkOutput("align.err_held", 32'(bus.pc_err), 32'h0);
`endif

    // PC wrap from 0xFFFF_FFFC to 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap.pc_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick(1);
    checkOutput("wrap.pc_zero", bus.imem_addr, 32'h0000_0000);
    checkOutput("wrap.pc8_id", bus.pc8_id, 32'h0000_0004);

    // Redirect ignored while ID is empty, then async reset mid-stream.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000);
    tick(1);
    checkOutput("invalid.redirect", bus.imem_addr, 32'h0000_3004);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(3);
    checkOutput("mid.pc_before", bus.imem_addr, 32'h0000_3010);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid.pc", bus.imem_addr, 32'h0000_3000);
    checkOutput("mid.valid_id", 32'(bus.valid_id), 32'h0);
    checkOutput("mid.pc_err", 32'(bus.pc_err), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checkOutput("mid.restart", bus.instr_id, 32'h0000_3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the P5 five-stage MIPS pipeline.
- Owns the PC register, the next-PC selection and the IF/ID pipeline register.
- Drives the instruction-memory address. Presents instr/PC to the ID stage, where opcode/funct go to the decode controller.
- Takes back the ID-stage redirect decisions (isb, isjal, isjr) and the jr target. Architectural branch delay slot; no flush.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ID_PC8_EN_DEFAULT, 1, reserved; must be 1. Link value is always PC+8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- stall  in  1  hazard unit: hold PC and IF/ID
- isb  in  1  ID-stage branch taken (controller output, already gated by compare)
- isjal  in  1  ID-stage jal
- isjr  in  1  ID-stage jr
- jr_target  in  32  forwarded rs value for jr
- imem_addr  out  32  fetch address, equal to PC (combinational)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- instr_id  out  32  IF/ID instruction
- pc_id  out  32  IF/ID PC
- pc8_id  out  32  IF/ID PC+8 (jal link value)
- valid_id  out  1  IF/ID holds a real fetched instruction
- pc_err  out  1  sticky misaligned-jr flag (only with PC_ALIGN_CHECK_EN; else tied 0)

Behaviour:
- Reset (rst_n low, async):
  - PC = RESET_PC.
  - instr_id = 0, pc_id = 0, pc8_id = 0, valid_id = 0, pc_err = 0.
- imem_addr = PC at all times.
- Next-PC computation (combinational, 32-bit, wrap mod 2^32):
  - seq = PC + 4
  - br = pc_id + 4 + (sign_extend(instr_id[15:0]) << 2)
  - j = {pc_id_plus4[31:28], instr_id[25:0], 2'b00}
  - jr = jr_target
- Next-PC priority: isjr > isjal > isb > seq. The decoder keeps the select inputs mutually exclusive; the priority only defines illegal combinations.
- Redirect inputs are honoured only when valid_id = 1. With valid_id = 0, next PC is seq regardless of isb/isjal/isjr.
- Rising edge, stall = 0:
  - PC <= next PC.
  - instr_id <= imem_rdata, pc_id <= PC, pc8_id <= PC + 8, valid_id <= 1.
- Rising edge, stall = 1:
  - PC, instr_id, pc_id, pc8_id and valid_id all hold.
  - Redirect inputs are ignored that cycle. ID re-evaluates on the held instruction next cycle, so the redirect is applied when stall drops.
- Delay slot:
  - A redirect taken in cycle N changes PC for cycle N+1.
  - The instruction fetched in cycle N (the delay slot) still enters IF/ID.
- Latency:
  - Instruction at address A reaches instr_id one edge after PC = A with no stall.
  - Redirect-to-fetch is 1 cycle.
- Reset release:
  - First edge after rst_n rises (stall = 0) loads IF/ID with the word at RESET_PC and sets valid_id = 1.
  - Fetch stays at RESET_PC until that edge.
- Reset mid-operation: immediate async return to the reset state; pc_err cleared.
- Wrap: PC = 32'hFFFF_FFFC with seq selected gives PC = 0. No exception is raised.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If isjr is selected with jr_target[1:0] != 0 (valid_id = 1, stall = 0), PC <= {jr_target[31:2], 2'b00}.
  - pc_err sets to 1 on that edge and stays set until reset.
- Not defined:
  - jr target is loaded unmodified.
  - pc_err is constant 0; no flag register exists.

Test Plan:
- Reset, release, 3 cycles stall = 0, imem word(addr) = addr:
  - imem_addr = 3000, 3004, 3008, 300C on successive cycles.
  - instr_id = 3000, 3004, 3008, valid_id = 1 from first edge.
  - pc8_id = 3008 when pc_id = 3000.
- Beq at 0x3004 with imm16 = 16'hFFFF, isb = 1 while it is in ID:
  - 0x3008 (delay slot) enters IF/ID.
  - Next fetch address = 0x3004.
- jal at 0x3000 with instr[25:0] = 26'h0000C40 and isjal = 1:
  - Fetch after the delay slot = 0x0000_3100.
  - pc8_id = 0x3008 while the jal sits in ID.
- isjr = 1, jr_target = 0x0000_4000, stall = 1 for 2 cycles then 0:
  - PC and IF/ID frozen for 2 cycles.
  - PC = 0x4000 on the edge after stall drops.
- Assert rst_n = 0 mid-stream (PC = 0x3010) between edges:
  - PC = 0x3000 and valid_id = 0 immediately, without waiting for a clock.
- PC_ALIGN_CHECK_EN defined, isjr with jr_target = 0x0000_3006:
  - PC = 0x3004 and pc_err = 1, held through later fetches.
  - Without the macro: PC = 0x3006 and pc_err = 0.
